// File: rtl/vedic_pkg.sv
// Shared types and widths for the sequential 16x16 Vedic multiplier.
//   state_t : scheduler states, 3-bit encoding
//   OPW/HALFW/ACCW/PW : operand, half-operand, accumulator and product widths
package vedic_pkg;

  localparam int unsigned OPW   = 16;
  localparam int unsigned HALFW = 8;
  localparam int unsigned ACCW  = 24;
  localparam int unsigned PW    = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LL   = 3'd1,
    HL   = 3'd2,
    LH   = 3'd3,
    HH   = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/half_adder_24bit.sv
// Shared 24-bit adder; carry-out is dropped because no accumulation step can
// exceed 24 bits.
//   i_x, i_y : addends
//   o_sum    : i_x + i_y modulo 2^24
module half_adder_24bit
  import vedic_pkg::*;
(
  input  logic [ACCW-1:0] i_x,
  input  logic [ACCW-1:0] i_y,
  output logic [ACCW-1:0] o_sum
);

  assign o_sum = i_x + i_y;

endmodule

// File: rtl/vedic_mult8.sv
// Combinational 8x8 unsigned Vedic (Urdhva-Tiryagbhyam) multiplier built
// recursively from 2x2 and 4x4 vertical-crosswise blocks.
//   i_a, i_b : 8-bit operands
//   o_p      : 16-bit product
module vedic_mult8
  import vedic_pkg::*;
(
  input  logic [HALFW-1:0]   i_a,
  input  logic [HALFW-1:0]   i_b,
  output logic [2*HALFW-1:0] o_p
);

  // 2x2 block: gate-level vertical and crosswise terms
  function automatic logic [3:0] vm2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, t3, c1;
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    t3 = x[1] & y[1];
    c1 = t1 & t2;
    return {t3 & c1, t3 ^ c1, t1 ^ t2, x[0] & y[0]};
  endfunction

  // 4x4 block: four 2x2 partials combined at their weights
  function automatic logic [7:0] vm4(input logic [3:0] x, input logic [3:0] y);
    logic [3:0] q0, q1, q2, q3;
    q0 = vm2(x[1:0], y[1:0]);
    q1 = vm2(x[3:2], y[1:0]);
    q2 = vm2(x[1:0], y[3:2]);
    q3 = vm2(x[3:2], y[3:2]);
    return 8'(q0) + (8'(q1) << 2) + (8'(q2) << 2) + (8'(q3) << 4);
  endfunction

  logic [7:0] w_q0, w_q1, w_q2, w_q3;

  assign w_q0 = vm4(i_a[3:0], i_b[3:0]);
  assign w_q1 = vm4(i_a[7:4], i_b[3:0]);
  assign w_q2 = vm4(i_a[3:0], i_b[7:4]);
  assign w_q3 = vm4(i_a[7:4], i_b[7:4]);

  assign o_p = 16'(w_q0) + (16'(w_q1) << 4) + (16'(w_q2) << 4) + (16'(w_q3) << 8);

endmodule

// File: rtl/vedic16_seq_mul_ctrl.sv
// Sequential 16x16 unsigned multiplier: one 8x8 Vedic multiplier and one
// 24-bit adder are time-shared over four partial-product cycles.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake, operands a, b
//   out_valid/out_ready : result handshake, product p (registered)
//   busy                : any state other than IDLE
module vedic16_seq_mul_ctrl
  import vedic_pkg::*;
#(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p,
  output logic          busy
);

  state_t             r_state;
  state_t             w_next;
  logic [HALFW-1:0]   r_ah, r_al, r_bh, r_bl;
  logic [ACCW-1:0]    r_acc;
  logic [HALFW-1:0]   r_lo8;
  logic [PW-1:0]      r_p;
  logic               r_out_valid;
  logic               r_busy;

  logic [HALFW-1:0]   w_ma, w_mb;
  logic [2*HALFW-1:0] w_m;
  logic [ACCW-1:0]    w_addx, w_addy, w_sum;
  logic               w_accept;
  logic               w_zero;

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_zero    = SKIP_ZERO && ((a == '0) || (b == '0));
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign p         = r_p;

  vedic_mult8 u_mult (
    .i_a (w_ma),
    .i_b (w_mb),
    .o_p (w_m)
  );

  half_adder_24bit u_add (
    .i_x   (w_addx),
    .i_y   (w_addy),
    .o_sum (w_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and state-selected datapath muxes; idle datapath in IDLE/DONE
  always_comb begin
    w_next = r_state;
    w_ma   = '0;
    w_mb   = '0;
    w_addx = '0;
    w_addy = '0;
    case (r_state)
      IDLE: if (w_accept) w_next = w_zero ? DONE : LL;
      LL: begin
        w_ma   = r_al;
        w_mb   = r_bl;
        w_addy = {16'h0, w_m[15:8]};
        w_next = HL;
      end
      HL: begin
        w_ma   = r_ah;
        w_mb   = r_bl;
        w_addx = r_acc;
        w_addy = {8'h0, w_m};
        w_next = LH;
      end
      LH: begin
        w_ma   = r_al;
        w_mb   = r_bh;
        w_addx = r_acc;
        w_addy = {8'h0, w_m};
        w_next = HH;
      end
      HH: begin
        w_ma   = r_ah;
        w_mb   = r_bh;
        w_addx = r_acc;
        w_addy = {w_m, 8'h0};
        w_next = DONE;
      end
      DONE: if (out_ready) w_next = w_accept ? (w_zero ? DONE : LL) : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, accumulation and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ah        <= '0;
      r_al        <= '0;
      r_bh        <= '0;
      r_bl        <= '0;
      r_acc       <= '0;
      r_lo8       <= '0;
      r_p         <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_next == DONE);
      r_busy      <= (w_next != IDLE);
      if (w_accept) begin
        {r_ah, r_al} <= a;
        {r_bh, r_bl} <= b;
      end
      case (r_state)
        LL: begin
          r_lo8 <= w_m[7:0];
          r_acc <= w_sum;
        end
        HL, LH: r_acc <= w_sum;
        // Product is published only here so p holds steady outside DONE
        HH: begin
          r_acc <= w_sum;
          r_p   <= {w_sum, r_lo8};
        end
        default: ;
      endcase
      // Zero operand short-circuits straight to a zero result
      if (w_accept && w_zero) begin
        r_acc <= '0;
        r_lo8 <= '0;
        r_p   <= '0;
      end
    end
  end

endmodule
